// File: rtl/matrix_ram_sequencer.sv
// rtl/matrix_ram_sequencer.sv - moves a ROWS x 4 signed matrix between a local buffer and a row-wide RAM
//
// Ports:
//   Clock, ResetN            clock, asynchronous active-low reset
//   Start, Direction         transfer request (1 = buffer->RAM, 0 = RAM->buffer)
//   BaseAddress              RAM address of row 0; row r lives at BaseAddress + r (mod 2^32)
//   BufWrite, BufRow, BufIn* host load of one buffer row; BufOut* shows row BufRow
//   Busy, Done               transfer in progress / one-cycle completion pulse
//   Ram*                     registered RAM command side, RamIn* is RAM read data
module matrix_ram_sequencer #(
    parameter  int WIDTH = 32,
    parameter  int ROWS  = 4,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    Clock,
    input  logic                    ResetN,
    input  logic                    Start,
    input  logic                    Direction,
    input  logic [31:0]             BaseAddress,
    input  logic                    BufWrite,
    input  logic [RW-1:0]           BufRow,
    input  logic signed [WIDTH-1:0] BufIn1,
    input  logic signed [WIDTH-1:0] BufIn2,
    input  logic signed [WIDTH-1:0] BufIn3,
    input  logic signed [WIDTH-1:0] BufIn4,
    output logic signed [WIDTH-1:0] BufOut1,
    output logic signed [WIDTH-1:0] BufOut2,
    output logic signed [WIDTH-1:0] BufOut3,
    output logic signed [WIDTH-1:0] BufOut4,
    output logic                    Busy,
    output logic                    Done,
    output logic                    RamEnable,
    output logic                    RamReadWrite,
    output logic [31:0]             RamAddress,
    output logic signed [WIDTH-1:0] RamOutColumn1,
    output logic signed [WIDTH-1:0] RamOutColumn2,
    output logic signed [WIDTH-1:0] RamOutColumn3,
    output logic signed [WIDTH-1:0] RamOutColumn4,
    input  logic signed [WIDTH-1:0] RamInColumn1,
    input  logic signed [WIDTH-1:0] RamInColumn2,
    input  logic signed [WIDTH-1:0] RamInColumn3,
    input  logic signed [WIDTH-1:0] RamInColumn4
);

    // Counter must reach ROWS: a read spends one extra cycle capturing the last row.
    localparam int CW = $clog2(ROWS + 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
    localparam logic [CW-1:0] CAP_END  = CW'(ROWS);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [31:0]             base_q, base_d;
    logic                    en_q, en_d;
    logic                    rw_q, rw_d;
    logic [31:0]             addr_q, addr_d;
    logic signed [WIDTH-1:0] col_q [4];
    logic signed [WIDTH-1:0] col_d [4];

    logic signed [WIDTH-1:0] mem_q [ROWS][4];

    logic                    buf_we;
    logic [RW-1:0]           buf_row;
    logic signed [WIDTH-1:0] buf_wdata [4];
    logic signed [WIDTH-1:0] buf_in [4];
    logic signed [WIDTH-1:0] ram_in [4];

    logic [CW-1:0]           cnt_inc, cnt_dec;
    logic [RW-1:0]           nxt_row, cap_row;
    logic [31:0]             nxt_addr;

    assign buf_in[0] = BufIn1;
    assign buf_in[1] = BufIn2;
    assign buf_in[2] = BufIn3;
    assign buf_in[3] = BufIn4;
    assign ram_in[0] = RamInColumn1;
    assign ram_in[1] = RamInColumn2;
    assign ram_in[2] = RamInColumn3;
    assign ram_in[3] = RamInColumn4;

    assign cnt_inc  = cnt_q + 1'b1;
    assign cnt_dec  = cnt_q - 1'b1;
    assign nxt_row  = cnt_inc[RW-1:0];
    assign cap_row  = cnt_dec[RW-1:0];
    assign nxt_addr = base_q + {{(32-CW){1'b0}}, cnt_inc};

    // RAM command for row 0 is registered at the Start edge so the first access
    // lands in the cycle right after Start; each state then prepares the next row.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        en_d      = 1'b0;
        rw_d      = rw_q;
        addr_d    = addr_q;
        col_d     = col_q;
        buf_we    = 1'b0;
        buf_row   = BufRow;
        buf_wdata = buf_in;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = Direction ? WRITE : READ;
                    cnt_d   = '0;
                    base_d  = BaseAddress;
                    en_d    = 1'b1;
                    rw_d    = Direction;
                    addr_d  = BaseAddress;
                    if (Direction) begin
                        col_d = mem_q[0];
                    end
                end else if (BufWrite) begin
                    buf_we = 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == LAST_ROW) begin
                    state_d = DONE;
                end else begin
                    cnt_d  = cnt_inc;
                    en_d   = 1'b1;
                    addr_d = nxt_addr;
                    col_d  = mem_q[nxt_row];
                end
            end
            READ: begin
                // Data for row cnt-1 is on RamIn this cycle.
                if (cnt_q != '0) begin
                    buf_we    = 1'b1;
                    buf_row   = cap_row;
                    buf_wdata = ram_in;
                end
                if (cnt_q == CAP_END) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q != LAST_ROW) begin
                        en_d   = 1'b1;
                        addr_d = nxt_addr;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            for (int c = 0; c < 4; c++) begin
                col_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            for (int c = 0; c < 4; c++) begin
                col_q[c] <= col_d[c];
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < 4; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (buf_we) begin
            for (int c = 0; c < 4; c++) begin
                mem_q[buf_row][c] <= buf_wdata[c];
            end
        end
    end

    assign BufOut1       = mem_q[BufRow][0];
    assign BufOut2       = mem_q[BufRow][1];
    assign BufOut3       = mem_q[BufRow][2];
    assign BufOut4       = mem_q[BufRow][3];
    assign Busy          = (state_q != IDLE);
    assign Done          = (state_q == DONE);
    assign RamEnable     = en_q;
    assign RamReadWrite  = rw_q;
    assign RamAddress    = addr_q;
    assign RamOutColumn1 = col_q[0];
    assign RamOutColumn2 = col_q[1];
    assign RamOutColumn3 = col_q[2];
    assign RamOutColumn4 = col_q[3];

endmodule

// File: tb/tb_matrix_ram_sequencer.sv
// tb/tb_matrix_ram_sequencer.sv - directed self-checking bench for matrix_ram_sequencer
module tb_matrix_ram_sequencer;

    localparam int WIDTH = 32;
    localparam int ROWS  = 4;

    logic Clock = 1'b0;
    logic ResetN, Start, Direction, BufWrite;
    logic [31:0] BaseAddress;
    logic [1:0] BufRow;
    logic signed [WIDTH-1:0] BufIn1, BufIn2, BufIn3, BufIn4;
    logic signed [WIDTH-1:0] BufOut1, BufOut2, BufOut3, BufOut4;
    logic Busy, Done, RamEnable, RamReadWrite;
    logic [31:0] RamAddress;
    logic signed [WIDTH-1:0] RamOutColumn1, RamOutColumn2, RamOutColumn3, RamOutColumn4;
    logic signed [WIDTH-1:0] rd1 = '0, rd2 = '0, rd3 = '0, rd4 = '0;

    matrix_ram_sequencer #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
        .Clock(Clock), .ResetN(ResetN), .Start(Start), .Direction(Direction),
        .BaseAddress(BaseAddress), .BufWrite(BufWrite), .BufRow(BufRow),
        .BufIn1(BufIn1), .BufIn2(BufIn2), .BufIn3(BufIn3), .BufIn4(BufIn4),
        .BufOut1(BufOut1), .BufOut2(BufOut2), .BufOut3(BufOut3), .BufOut4(BufOut4),
        .Busy(Busy), .Done(Done), .RamEnable(RamEnable), .RamReadWrite(RamReadWrite),
        .RamAddress(RamAddress),
        .RamOutColumn1(RamOutColumn1), .RamOutColumn2(RamOutColumn2),
        .RamOutColumn3(RamOutColumn3), .RamOutColumn4(RamOutColumn4),
        .RamInColumn1(rd1), .RamInColumn2(rd2), .RamInColumn3(rd3), .RamInColumn4(rd4)
    );

    always #5 Clock = ~Clock;

    // Small RAM indexed by the low address nibble, plus an access log.
    logic [4*WIDTH-1:0] ram [16];
    logic [31:0]        log_addr [$];
    logic               log_rw [$];
    logic signed [31:0] log_c1 [$];

    always @(posedge Clock) begin
        if (RamEnable) begin
            log_addr.push_back(RamAddress);
            log_rw.push_back(RamReadWrite);
            log_c1.push_back(RamOutColumn1);
            if (RamReadWrite) begin
                ram[RamAddress[3:0]] <= {RamOutColumn1, RamOutColumn2, RamOutColumn3, RamOutColumn4};
            end else begin
                {rd1, rd2, rd3, rd4} <= ram[RamAddress[3:0]];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_at, ndone;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_row(input string tag, input int r, input int e1, input int e2, input int e3, input int e4);
        BufRow = 2'(r);
        #1;
        check({tag, "_c1"}, BufOut1, e1);
        check({tag, "_c2"}, BufOut2, e2);
        check({tag, "_c3"}, BufOut3, e3);
        check({tag, "_c4"}, BufOut4, e4);
    endtask

    task automatic load_row(input int r, input int a, input int b, input int c, input int d);
        BufWrite = 1'b1;
        BufRow   = 2'(r);
        BufIn1 = a; BufIn2 = b; BufIn3 = c; BufIn4 = d;
        @(negedge Clock);
        BufWrite = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge inside cycle 1 after the Start edge.
    task automatic go(input logic dir, input logic [31:0] base);
        Direction   = dir;
        BaseAddress = base;
        Start       = 1'b1;
        log_addr.delete();
        log_rw.delete();
        log_c1.delete();
        @(negedge Clock);
        Start    = 1'b0;
        BufWrite = 1'b0;
        cyc      = 1;
    endtask

    task automatic run(input int n, output int d_at, output int nd);
        d_at = 0;
        nd   = 0;
        for (int k = 0; k < n; k++) begin
            if (Done) begin
                nd++;
                if (d_at == 0) d_at = cyc;
            end
            @(negedge Clock);
            cyc++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = '0;
        ResetN = 1'b0; Start = 1'b0; Direction = 1'b0; BufWrite = 1'b0;
        BaseAddress = '0; BufRow = '0;
        BufIn1 = '0; BufIn2 = '0; BufIn3 = '0; BufIn4 = '0;
        repeat (2) @(negedge Clock);

        check("rst_en", RamEnable, 0);
        check("rst_rw", RamReadWrite, 0);
        check("rst_addr", RamAddress, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_out1", RamOutColumn1, 0);
        check_row("rst_buf", 0, 0, 0, 0, 0);
        ResetN = 1'b1;
        @(negedge Clock);

        // Basic write from Base=0
        load_row(0, -4, 2, -4, 7);
        go(1'b1, 32'd0);
        check("w0_busy", Busy, 1);
        check("w0_en", RamEnable, 1);
        check("w0_rw", RamReadWrite, 1);
        check("w0_addr", RamAddress, 0);
        check("w0_c1", RamOutColumn1, -4);
        check("w0_c2", RamOutColumn2, 2);
        check("w0_c3", RamOutColumn3, -4);
        check("w0_c4", RamOutColumn4, 7);
        run(10, done_at, ndone);
        check("w0_done_cyc", done_at, 5);
        check("w0_ndone", ndone, 1);
        check("w0_nacc", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("w0_acc_addr", log_addr[i], i);
                check("w0_acc_rw", log_rw[i], 1);
            end
        end

        // Write at Base=4, clobber buffer row 0, read back
        load_row(0, 3, 83, -88, 92);
        load_row(1, 11, -12, 13, -14);
        load_row(2, 21, 22, 23, 24);
        load_row(3, -31, 32, -33, 34);
        go(1'b1, 32'd4);
        run(10, done_at, ndone);
        check("w4_done_cyc", done_at, 5);
        load_row(0, 1, 1, 1, 1);
        go(1'b0, 32'd4);
        check("r4_rw", RamReadWrite, 0);
        check("r4_addr", RamAddress, 4);
        run(4, done_at, ndone);
        check("r4_cap_en", RamEnable, 0);
        check("r4_cap_busy", Busy, 1);
        run(6, done_at, ndone);
        check("r4_done_cyc", done_at, 6);
        check("r4_ndone", ndone, 1);
        check("r4_nacc", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("r4_acc_addr", log_addr[i], 4 + i);
                check("r4_acc_rw", log_rw[i], 0);
            end
        end
        check_row("r4_row0", 0, 3, 83, -88, 92);
        check_row("r4_row1", 1, 11, -12, 13, -14);
        check_row("r4_row2", 2, 21, 22, 23, 24);
        check_row("r4_row3", 3, -31, 32, -33, 34);

        // Start pulsed during a busy write is ignored
        go(1'b1, 32'd8);
        @(negedge Clock); cyc++;
        Start = 1'b1; Direction = 1'b0;
        @(negedge Clock); cyc++;
        Start = 1'b0;
        run(12, done_at, ndone);
        check("busy_start_ndone", ndone, 1);
        check("busy_start_done_cyc", done_at, 5);
        check("busy_start_nacc", log_addr.size(), 4);

        // Address wrap
        go(1'b1, 32'hFFFF_FFFE);
        run(8, done_at, ndone);
        check("wrap_nacc", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            check("wrap_a0", log_addr[0], 32'hFFFF_FFFE);
            check("wrap_a1", log_addr[1], 32'hFFFF_FFFF);
            check("wrap_a2", log_addr[2], 32'h0000_0000);
            check("wrap_a3", log_addr[3], 32'h0000_0001);
        end

        // Reset during the 2nd read cycle
        go(1'b0, 32'd4);
        @(negedge Clock); cyc++;
        ResetN = 1'b0;
        #1;
        check("mrst_en", RamEnable, 0);
        check("mrst_busy", Busy, 0);
        check("mrst_done", Done, 0);
        check("mrst_addr", RamAddress, 0);
        for (int r = 0; r < ROWS; r++) begin
            check_row("mrst_buf", r, 0, 0, 0, 0);
        end
        @(negedge Clock); cyc++;
        ResetN = 1'b1;
        run(8, done_at, ndone);
        check("mrst_ndone", ndone, 0);
        check("mrst_nacc", log_addr.size(), 1);

        // BufWrite together with Start: Start wins, old contents used
        load_row(0, 10, 20, 30, 40);
        BufWrite = 1'b1; BufRow = 2'd0;
        BufIn1 = 99; BufIn2 = 98; BufIn3 = 97; BufIn4 = 96;
        go(1'b1, 32'd0);
        check("sw_c1", RamOutColumn1, 10);
        check("sw_c4", RamOutColumn4, 40);
        run(8, done_at, ndone);
        check("sw_done_cyc", done_at, 5);
        if (log_c1.size() > 0) check("sw_log_c1", log_c1[0], 10);
        check_row("sw_row0", 0, 10, 20, 30, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
